// File: rtl/exec_stage_mc.sv
// Execute stage: valid/ready on both sides, NZP-based branch resolution and a
// multi-cycle multiplier. All state updates happen on the falling clock edge.
module exec_stage_mc #(
    parameter int REG_WIDTH     = 16,
    parameter int PC_WIDTH      = 16,
    parameter int OPCODE_WIDTH  = 8,
    parameter int REG_IDX_WIDTH = 4,
    parameter int MUL_LATENCY   = 3
) (
    input  logic                     I_CLOCK,
    input  logic                     I_RESET_N,
    input  logic                     I_Valid,
    output logic                     O_Ready,
    input  logic [PC_WIDTH-1:0]      I_PC,
    input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
    input  logic [REG_WIDTH-1:0]     I_Src1Value,
    input  logic [REG_WIDTH-1:0]     I_Src2Value,
    input  logic [REG_WIDTH-1:0]     I_Imm,
    input  logic [REG_IDX_WIDTH-1:0] I_DestRegIdx,
    input  logic [REG_WIDTH-1:0]     I_DestValue,
    output logic                     O_Valid,
    input  logic                     I_Ready,
    output logic [OPCODE_WIDTH-1:0]  O_Opcode,
    output logic [REG_WIDTH-1:0]     O_ALUOut,
    output logic [REG_IDX_WIDTH-1:0] O_DestRegIdx,
    output logic [REG_WIDTH-1:0]     O_DestValue,
    output logic                     O_BranchTaken,
    output logic [PC_WIDTH-1:0]      O_BranchTarget,
    output logic [2:0]               O_NZP
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD   = OPCODE_WIDTH'(8'h01);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(8'h02);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND   = OPCODE_WIDTH'(8'h03);
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = OPCODE_WIDTH'(8'h04);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV   = OPCODE_WIDTH'(8'h05);
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI  = OPCODE_WIDTH'(8'h06);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = OPCODE_WIDTH'(8'h07);
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = OPCODE_WIDTH'(8'h08);
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL   = OPCODE_WIDTH'(8'h09);
    // Conditional branches carry their {N,Z,P} mask in the low three bits.
    localparam logic [OPCODE_WIDTH-1:0] OP_BRP   = OPCODE_WIDTH'(8'h11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = OPCODE_WIDTH'(8'h17);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(8'h20);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR   = OPCODE_WIDTH'(8'h21);
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR  = OPCODE_WIDTH'(8'h22);

    typedef enum logic [0:0] {S_RUN = 1'b0, S_MUL_BUSY = 1'b1} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
    logic [REG_WIDTH-1:0]     aluout_q, aluout_d;
    logic [REG_IDX_WIDTH-1:0] dest_idx_q, dest_idx_d;
    logic [REG_WIDTH-1:0]     dest_val_q, dest_val_d;
    logic                     br_taken_q, br_taken_d;
    logic [PC_WIDTH-1:0]      br_target_q, br_target_d;
    logic [2:0]               nzp_q, nzp_d;
    logic [REG_WIDTH-1:0]     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [REG_IDX_WIDTH-1:0] mul_idx_q, mul_idx_d;
    logic [REG_WIDTH-1:0]     mul_dval_q, mul_dval_d;

    logic                     out_free, accept, is_branch, br_cond;
    logic [REG_WIDTH-1:0]     alu_res, in_prod, mul_res;
    logic [PC_WIDTH-1:0]      rel_target;

    function automatic logic [2:0] nzp_of(input logic [REG_WIDTH-1:0] v);
        if (v[REG_WIDTH-1])  return 3'b100;
        else if (v == '0)    return 3'b010;
        else                 return 3'b001;
    endfunction

    // Low bits of a two's-complement product do not depend on signedness.
    assign in_prod    = I_Src1Value * I_Src2Value;
    assign mul_res    = mul_a_q * mul_b_q;
    assign rel_target = I_PC + PC_WIDTH'(I_Imm);
    assign is_branch  = (I_Opcode >= OP_BRP) && (I_Opcode <= OP_BRNZP);
    assign br_cond    = |(I_Opcode[2:0] & nzp_q);
    assign out_free   = !valid_q || I_Ready;
    assign O_Ready    = (state_q == S_RUN) && out_free;
    assign accept     = I_Valid && O_Ready;

    always_comb begin
        alu_res = I_Src1Value + I_Imm;
        case (I_Opcode)
            OP_ADD:  alu_res = I_Src1Value + I_Src2Value;
            OP_AND:  alu_res = I_Src1Value & I_Src2Value;
            OP_ANDI: alu_res = I_Src1Value & I_Imm;
            OP_MOV:  alu_res = I_Src1Value;
            OP_MOVI: alu_res = I_Imm;
            default: alu_res = I_Src1Value + I_Imm;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        aluout_d    = aluout_q;
        dest_idx_d  = dest_idx_q;
        dest_val_d  = dest_val_q;
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        nzp_d       = nzp_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_idx_d   = mul_idx_q;
        mul_dval_d  = mul_dval_q;

        if (state_q == S_RUN) begin
            if (out_free) valid_d = 1'b0;
            if (accept) begin
                case (I_Opcode)
                    OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_MOV, OP_MOVI, OP_LDW, OP_STW: begin
                        valid_d    = 1'b1;
                        opcode_d   = I_Opcode;
                        aluout_d   = alu_res;
                        dest_idx_d = I_DestRegIdx;
                        dest_val_d = I_DestValue;
                        if (I_Opcode != OP_LDW && I_Opcode != OP_STW) nzp_d = nzp_of(alu_res);
                    end
                    OP_MUL: begin
                        if (MUL_LATENCY == 1) begin
                            valid_d    = 1'b1;
                            opcode_d   = OP_MUL;
                            aluout_d   = in_prod;
                            dest_idx_d = I_DestRegIdx;
                            dest_val_d = I_DestValue;
                            nzp_d      = nzp_of(in_prod);
                        end else begin
                            state_d    = S_MUL_BUSY;
                            cnt_d      = CNT_W'(MUL_LATENCY - 1);
                            mul_a_d    = I_Src1Value;
                            mul_b_d    = I_Src2Value;
                            mul_idx_d  = I_DestRegIdx;
                            mul_dval_d = I_DestValue;
                        end
                    end
                    OP_JMP: begin
                        br_taken_d  = 1'b1;
                        br_target_d = PC_WIDTH'(I_Src1Value);
                    end
                    OP_JSR, OP_JSRR: begin
                        br_taken_d  = 1'b1;
                        br_target_d = (I_Opcode == OP_JSR) ? rel_target : PC_WIDTH'(I_Src1Value);
                        valid_d     = 1'b1;
                        opcode_d    = I_Opcode;
                        aluout_d    = REG_WIDTH'(I_PC);
                        dest_idx_d  = I_DestRegIdx;
                        dest_val_d  = I_DestValue;
                    end
                    default: begin
                        // Branches and unknown opcodes consume the slot without a result.
                        if (is_branch && br_cond) begin
                            br_taken_d  = 1'b1;
                            br_target_d = rel_target;
                        end
                    end
                endcase
            end
        end else begin
            // The previous result may still drain while the multiplier works.
            if (valid_q && I_Ready) valid_d = 1'b0;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else if (out_free) begin
                state_d    = S_RUN;
                valid_d    = 1'b1;
                opcode_d   = OP_MUL;
                aluout_d   = mul_res;
                dest_idx_d = mul_idx_q;
                dest_val_d = mul_dval_q;
                nzp_d      = nzp_of(mul_res);
            end
        end
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            aluout_q    <= '0;
            dest_idx_q  <= '0;
            dest_val_q  <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            nzp_q       <= 3'b010;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_idx_q   <= '0;
            mul_dval_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            aluout_q    <= aluout_d;
            dest_idx_q  <= dest_idx_d;
            dest_val_q  <= dest_val_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            nzp_q       <= nzp_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_idx_q   <= mul_idx_d;
            mul_dval_q  <= mul_dval_d;
        end
    end

    assign O_Valid        = valid_q;
    assign O_Opcode       = opcode_q;
    assign O_ALUOut       = aluout_q;
    assign O_DestRegIdx   = dest_idx_q;
    assign O_DestValue    = dest_val_q;
    assign O_BranchTaken  = br_taken_q;
    assign O_BranchTarget = br_target_q;
    assign O_NZP          = nzp_q;

endmodule

// File: tb/tb_exec_stage_mc.sv
// Bench for exec_stage_mc: directed scenarios plus random traffic, checked
// against a timestamp-based reference model and a result scoreboard.
module tb_exec_stage_mc;
  localparam int W = 16;
  localparam int PW = 16;
  localparam int OW = 8;
  localparam int IW = 4;
  localparam int LAT = 3;

  localparam logic [7:0] OP_ADD = 8'h01, OP_ADDI = 8'h02, OP_AND = 8'h03, OP_ANDI = 8'h04;
  localparam logic [7:0] OP_MOV = 8'h05, OP_MOVI = 8'h06, OP_LDW = 8'h07, OP_STW = 8'h08;
  localparam logic [7:0] OP_MUL = 8'h09;
  localparam logic [7:0] OP_BRP = 8'h11, OP_BRZ = 8'h12, OP_BRZP = 8'h13, OP_BRN = 8'h14;
  localparam logic [7:0] OP_BRNP = 8'h15, OP_BRNZ = 8'h16, OP_BRNZP = 8'h17;
  localparam logic [7:0] OP_JMP = 8'h20, OP_JSR = 8'h21, OP_JSRR = 8'h22;
  localparam logic [7:0] OPS [0:20] = '{OP_ADD, OP_ADDI, OP_AND, OP_ANDI, OP_MOV, OP_MOVI,
    OP_LDW, OP_STW, OP_MUL, OP_BRP, OP_BRZ, OP_BRZP, OP_BRN, OP_BRNP, OP_BRNZ, OP_BRNZP,
    OP_JMP, OP_JSR, OP_JSRR, 8'h10, 8'hFF};

  // clock/reset
  logic clk, rst_n;
  logic i_valid, o_ready, o_valid, i_ready, o_br_taken;
  logic [PW-1:0] i_pc, o_br_target;
  logic [OW-1:0] i_opcode, o_opcode;
  logic [W-1:0] i_src1, i_src2, i_imm, i_dval, o_aluout, o_dval;
  logic [IW-1:0] i_idx, o_idx;
  logic [2:0] o_nzp;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  exec_stage_mc #(.REG_WIDTH(W), .PC_WIDTH(PW), .OPCODE_WIDTH(OW), .REG_IDX_WIDTH(IW),
                  .MUL_LATENCY(LAT)) dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_Valid(i_valid), .O_Ready(o_ready),
    .I_PC(i_pc), .I_Opcode(i_opcode), .I_Src1Value(i_src1), .I_Src2Value(i_src2),
    .I_Imm(i_imm), .I_DestRegIdx(i_idx), .I_DestValue(i_dval), .O_Valid(o_valid),
    .I_Ready(i_ready), .O_Opcode(o_opcode), .O_ALUOut(o_aluout), .O_DestRegIdx(o_idx),
    .O_DestValue(o_dval), .O_BranchTaken(o_br_taken), .O_BranchTarget(o_br_target),
    .O_NZP(o_nzp));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural view of the output register, the NZP
  // register and a pending multiply that becomes eligible at edge m_due.
  bit m_valid, m_busy, m_br;
  logic [7:0] m_op;
  logic [W-1:0] m_alu, m_dval, m_ma, m_mb, m_mdv;
  logic [IW-1:0] m_idx, m_midx;
  logic [PW-1:0] m_tgt;
  logic [2:0] m_nzp;
  int edge_no, m_due;

  function automatic logic [2:0] cc(input logic [W-1:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 0) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [2:0] br_mask(input logic [7:0] op);
    case (op)
      OP_BRN:   return 3'b100;
      OP_BRZ:   return 3'b010;
      OP_BRP:   return 3'b001;
      OP_BRNZ:  return 3'b110;
      OP_BRNP:  return 3'b101;
      OP_BRZP:  return 3'b011;
      OP_BRNZP: return 3'b111;
      default:  return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_busy = 0; m_br = 0; m_op = 0; m_alu = 0; m_dval = 0;
    m_idx = 0; m_tgt = 0; m_nzp = 3'b010; edge_no = 0; m_due = 0;
    exp_q.delete();
  endtask

  task automatic model_put(input logic [7:0] op, input logic [W-1:0] res,
                           input logic [IW-1:0] idx, input logic [W-1:0] dv, input bit upd);
    m_valid = 1; m_op = op; m_alu = res; m_idx = idx; m_dval = dv;
    if (upd) m_nzp = cc(res);
    exp_q.push_back(res);
  endtask

  task automatic model_step();
    bit free;
    int p;
    free = !m_valid || i_ready;
    edge_no++;
    if (m_valid && i_ready) begin
      check_eq("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) check_eq("consumed", o_aluout, exp_q.pop_front());
    end
    m_br = 0;
    if (m_busy) begin
      if (m_valid && i_ready) m_valid = 0;
      if (edge_no >= m_due && free) begin
        p = int'($signed(m_ma)) * int'($signed(m_mb));
        m_busy = 0;
        model_put(OP_MUL, p[W-1:0], m_midx, m_mdv, 1);
      end
    end else begin
      if (free) m_valid = 0;
      if (i_valid && free) begin
        case (i_opcode)
          OP_ADD:  model_put(i_opcode, i_src1 + i_src2, i_idx, i_dval, 1);
          OP_ADDI: model_put(i_opcode, i_src1 + i_imm, i_idx, i_dval, 1);
          OP_AND:  model_put(i_opcode, i_src1 & i_src2, i_idx, i_dval, 1);
          OP_ANDI: model_put(i_opcode, i_src1 & i_imm, i_idx, i_dval, 1);
          OP_MOV:  model_put(i_opcode, i_src1, i_idx, i_dval, 1);
          OP_MOVI: model_put(i_opcode, i_imm, i_idx, i_dval, 1);
          OP_LDW, OP_STW: model_put(i_opcode, i_src1 + i_imm, i_idx, i_dval, 0);
          OP_MUL: begin
            if (LAT == 1) begin
              p = int'($signed(i_src1)) * int'($signed(i_src2));
              model_put(OP_MUL, p[W-1:0], i_idx, i_dval, 1);
            end else begin
              m_busy = 1; m_due = edge_no + LAT;
              m_ma = i_src1; m_mb = i_src2; m_midx = i_idx; m_mdv = i_dval;
            end
          end
          OP_JMP: begin m_br = 1; m_tgt = i_src1; end
          OP_JSR: begin m_br = 1; m_tgt = i_pc + i_imm; model_put(i_opcode, i_pc, i_idx, i_dval, 0); end
          OP_JSRR: begin m_br = 1; m_tgt = i_src1; model_put(i_opcode, i_pc, i_idx, i_dval, 0); end
          default: begin
            if ((br_mask(i_opcode) & m_nzp) != 3'b000) begin
              m_br = 1; m_tgt = i_pc + i_imm;
            end
          end
        endcase
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("valid", o_valid, m_valid);
    check_eq("nzp", o_nzp, m_nzp);
    check_eq("br_taken", o_br_taken, m_br);
    if (m_br) check_eq("br_target", o_br_target, m_tgt);
    if (m_valid) begin
      check_eq("opcode", o_opcode, m_op);
      check_eq("aluout", o_aluout, m_alu);
      check_eq("dest_idx", o_idx, m_idx);
      if (m_op == OP_STW) check_eq("dest_value", o_dval, m_dval);
    end
  endtask

  // driver: called at posedge+1, returns at the next posedge+1
  task automatic cycle(input bit v, input logic [7:0] op, input logic [PW-1:0] pc,
                       input logic [W-1:0] s1, input logic [W-1:0] s2, input logic [W-1:0] imm,
                       input logic [IW-1:0] idx, input logic [W-1:0] dv, input bit rdy);
    check_outputs();
    i_valid = v; i_opcode = op; i_pc = pc; i_src1 = s1; i_src2 = s2;
    i_imm = imm; i_idx = idx; i_dval = dv; i_ready = rdy;
    #1;
    check_eq("ready", o_ready, !m_busy && (!m_valid || rdy));
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 8'h00, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    rst_n = 0; i_valid = 0; i_opcode = 0; i_pc = 0; i_src1 = 0; i_src2 = 0;
    i_imm = 0; i_idx = 0; i_dval = 0; i_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", o_valid, 0);
    check_eq("rst_br", o_br_taken, 0);
    check_eq("rst_alu", o_aluout, 0);
    check_eq("rst_dval", o_dval, 0);
    check_eq("rst_tgt", o_br_target, 0);
    check_eq("rst_op", o_opcode, 0);
    check_eq("rst_idx", o_idx, 0);
    check_eq("rst_nzp", o_nzp, 3'b010);
    rst_n = 1;

    // back-to-back ALU
    cycle(1, OP_ADDI, 16'h0000, 16'h0005, 16'h0000, 16'hFFFE, 4'd1, 16'h0, 1);
    check_eq("tp_addi_alu", o_aluout, 16'h0003);
    check_eq("tp_addi_nzp", o_nzp, 3'b001);
    cycle(1, OP_AND, 16'h0000, 16'h00F0, 16'h0F0F, 16'h0000, 4'd2, 16'h0, 1);
    check_eq("tp_and_alu", o_aluout, 16'h0000);
    check_eq("tp_and_nzp", o_nzp, 3'b010);
    check_eq("tp_and_valid", o_valid, 1);

    // backpressure
    repeat (3) cycle(1, OP_ADD, 16'h0, 16'h1234, 16'h0101, 16'h0, 4'd3, 16'h0, 0);
    check_eq("tp_hold_alu", o_aluout, 16'h0000);
    check_eq("tp_hold_valid", o_valid, 1);
    cycle(1, OP_ADD, 16'h0, 16'h1234, 16'h0101, 16'h0, 4'd3, 16'h0, 1);
    check_eq("tp_bp_alu", o_aluout, 16'h1335);

    // branches
    cycle(1, OP_ADDI, 16'h0, 16'h0000, 16'h0, 16'hFFFF, 4'd4, 16'h0, 1);
    check_eq("tp_neg_nzp", o_nzp, 3'b100);
    cycle(1, OP_BRN, 16'h0010, 16'h0, 16'h0, 16'h0004, 4'd0, 16'h0, 1);
    check_eq("tp_brn_taken", o_br_taken, 1);
    check_eq("tp_brn_tgt", o_br_target, 16'h0014);
    check_eq("tp_brn_valid", o_valid, 0);
    cycle(1, OP_BRZP, 16'h0010, 16'h0, 16'h0, 16'h0004, 4'd0, 16'h0, 1);
    check_eq("tp_brzp_taken", o_br_taken, 0);

    // multiply
    cycle(1, OP_MOVI, 16'h0, 16'h0, 16'h0, 16'h0007, 4'd5, 16'h0, 1);
    cycle(1, OP_MUL, 16'h0, 16'hFFFD, 16'h0004, 16'h0, 4'd6, 16'h0, 1);
    repeat (3) cycle(1, OP_ADD, 16'h0, 16'h1, 16'h1, 16'h0, 4'd7, 16'h0, 1);
    check_eq("tp_mul_alu", o_aluout, 16'hFFF4);
    check_eq("tp_mul_nzp", o_nzp, 3'b100);
    check_eq("tp_mul_valid", o_valid, 1);

    // JSRR
    cycle(1, OP_JSRR, 16'h0031, 16'h0200, 16'h0, 16'h0, 4'd7, 16'h0, 1);
    check_eq("tp_jsrr_tgt", o_br_target, 16'h0200);
    check_eq("tp_jsrr_alu", o_aluout, 16'h0031);
    check_eq("tp_jsrr_valid", o_valid, 1);

    // reset mid-multiply
    cycle(1, OP_MUL, 16'h0, 16'h0003, 16'h0005, 16'h0, 4'd8, 16'h0, 1);
    idle(1);
    rst_n = 0;
    #1;
    check_eq("mr_valid", o_valid, 0);
    check_eq("mr_alu", o_aluout, 0);
    check_eq("mr_nzp", o_nzp, 3'b010);
    check_eq("mr_ready", o_ready, 1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    repeat (5) idle(1);

    // random traffic
    for (int n = 0; n < 500; n++) begin
      logic [W-1:0] s2;
      s2 = ($urandom_range(0, 3) == 0) ? 16'h0000 : W'($urandom);
      cycle($urandom_range(0, 9) < 7, OPS[$urandom_range(0, 20)], PW'($urandom), W'($urandom),
            s2, W'($urandom), IW'($urandom), W'($urandom), $urandom_range(0, 3) != 0);
    end
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_stage_mc.md
Name: exec_stage_mc

Overview:
Parametrised execute stage for the 5-stage core, sitting between decode and memory. It adds the following over the previous execute stage:
- a valid/ready handshake on both sides, replacing the lock/stall pass-through;
- branch resolution against an NZP condition-code register, with a flush pulse;
- a multi-cycle multiply unit.
Single issue, one output register, in-order.

Parameters:
REG_WIDTH, 16, datapath width
PC_WIDTH, 16, program-counter width
OPCODE_WIDTH, 8, opcode width (global opcode macros)
REG_IDX_WIDTH, 4, register index width
MUL_LATENCY, 3, cycles the multiplier occupies the stage (>=1)

Ports:
I_CLOCK  in  1  clock; all state updates on falling edge
I_RESET_N  in  1  asynchronous active-low reset
I_Valid  in  1  decode presents an instruction
O_Ready  out  1  stage can accept an instruction this cycle
I_PC  in  PC_WIDTH  PC of the incoming instruction, already incremented
I_Opcode  in  OPCODE_WIDTH  opcode
I_Src1Value  in  REG_WIDTH  source 1 value
I_Src2Value  in  REG_WIDTH  source 2 value
I_Imm  in  REG_WIDTH  sign-extended immediate / branch offset
I_DestRegIdx  in  REG_IDX_WIDTH  destination register index
I_DestValue  in  REG_WIDTH  store data
O_Valid  out  1  output register holds a result
I_Ready  in  1  memory stage accepts the result
O_Opcode  out  OPCODE_WIDTH  opcode of the result
O_ALUOut  out  REG_WIDTH  ALU result / memory address / link value
O_DestRegIdx  out  REG_IDX_WIDTH  destination index
O_DestValue  out  REG_WIDTH  store data
O_BranchTaken  out  1  one-cycle pulse: redirect fetch
O_BranchTarget  out  PC_WIDTH  target, valid when O_BranchTaken=1
O_NZP  out  3  current condition codes

Behaviour:
- Reset (async, I_RESET_N=0):
  - O_Valid=0, O_BranchTaken=0.
  - O_ALUOut, O_DestValue, O_BranchTarget, O_Opcode, O_DestRegIdx = 0.
  - O_NZP=3'b010. State=RUN, multiply counter=0.
  - Reset mid-multiply abandons the operation; no output.
- Acceptance:
  - O_Ready = (state==RUN) && (!O_Valid || I_Ready). O_Ready is combinational.
  - An instruction is accepted on a falling edge with I_Valid && O_Ready.
  - If O_Valid && !I_Ready, all outputs hold unchanged.
  - If O_Valid && I_Ready and nothing is accepted, O_Valid clears.
- Latency for single-cycle ops: the result is registered on the accept edge (1 cycle).
- Operations (wrap modulo 2^REG_WIDTH, no overflow flag):
  - ADD/ADDI: signed add.
  - AND/ANDI: bitwise AND.
  - MOV/MOVI: Src1, or Imm for MOVI.
  - LDW/STW: address = Src1 + Imm.
  - STW: O_DestValue = I_DestValue.
  - MUL: low REG_WIDTH bits of the signed product.
- Condition codes: every register-writing op (ADD, ADDI, AND, ANDI, MOV, MOVI, MUL; not LDW) updates NZP from its result on the edge the result is registered. Codes are one-hot: N if MSB=1, Z if 0, else P.
- Branches (BRN..BRNZP):
  - Taken iff (opcode nzp mask & O_NZP) != 0, where O_NZP is the value before this edge.
  - Target = I_PC + I_Imm.
  - JMP: taken unconditionally, target = Src1.
  - JSR: target = I_PC + Imm. JSRR: target = Src1.
  - JSR/JSRR also produce O_ALUOut = I_PC (link), O_DestRegIdx = I_DestRegIdx, O_Valid=1.
  - Branches and JMP set O_Valid=0; they consume the slot without emitting a result.
  - O_BranchTaken is high exactly one cycle after acceptance, then low.
- Multiply FSM:
  - RUN -> MUL_BUSY on MUL accept; operands are latched and counter=MUL_LATENCY-1.
  - In MUL_BUSY, the counter decrements each edge; O_Ready=0.
  - At counter==0, the result is written to the output register when (!O_Valid || I_Ready), then the FSM returns to RUN. Otherwise it stays in MUL_BUSY holding the result.
  - MUL_LATENCY=1 behaves as a single-cycle op.
- Unknown opcode: accepted, O_Valid=0, no NZP change.
- Simultaneous events: the output is consumed and a new instruction accepted on the same edge, giving full throughput of 1 instruction/cycle.

Test Plan:
- Back-to-back ALU, I_Ready=1: ADDI Src1=0x0005, Imm=0xFFFE, then AND 0x00F0&0x0F0F -> O_ALUOut 0x0003 then 0x0000, O_NZP 001 then 010, O_Valid high 2 consecutive cycles.
- Backpressure: I_Ready=0 with O_Valid=1, new ADD presented -> O_Ready=0, outputs held for 3 cycles; I_Ready=1 -> next result registered on the following edge.
- Branch: O_NZP=100, BRN with I_PC=0x0010, Imm=0x0004 -> O_BranchTaken pulse of 1 cycle, O_BranchTarget=0x0014, O_Valid=0. BRZP in the same state -> no pulse.
- Multiply, MUL_LATENCY=3: 0xFFFD*0x0004 -> O_Ready low 3 cycles, then O_ALUOut=0xFFF4, O_NZP=100.
- JSRR Src1=0x0200, I_PC=0x0031 -> O_BranchTarget=0x0200, O_ALUOut=0x0031, O_Valid=1.
- Reset asserted mid-MUL_BUSY -> all outputs zero, O_NZP=010, O_Ready=1 after release; no stale result appears.
